// File: rtl/encap_packet.sv
// encap_packet
//   Transmit-side packetiser for the DFX link. One DATA_DFX_WIDTH-bit packet
//   (data + address) is accepted per valid/ready handshake. It is sent on the
//   Aurora TX user interface as NUM_BEATS 64-bit words. Each word carries
//   55 payload bits in [63:9] and a 9-bit header in [8:0].
//   Header layout: [8]=SOP, [7]=EOP, [6:2]=beat index, [1:0]=0.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   data_dfx_send   packet to send
//   valid_dfx_send  packet valid
//   ready_dfx_send  block can accept a packet (combinational from tx_tready
//                   during the last beat so packets stream without a gap)
//   tx_tdata        Aurora TX word
//   tx_tvalid       tx_tdata valid
//   tx_tlast        final word of the packet
//   tx_tready       Aurora core accepts the word
//   pkt_sent_cnt    completed-packet count, wraps at 16 bits
module encap_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_send,
  input  logic                         valid_dfx_send,
  output logic                         ready_dfx_send,
  output logic [AURORA_DATA_WIDTH-1:0] tx_tdata,
  output logic                         tx_tvalid,
  output logic                         tx_tlast,
  input  logic                         tx_tready,
  output logic [15:0]                  pkt_sent_cnt
);

  localparam int HDR_WIDTH    = 9;
  localparam int PAYLOAD_BITS = AURORA_DATA_WIDTH - HDR_WIDTH;
  localparam int NUM_BEATS    = (DATA_DFX_WIDTH + PAYLOAD_BITS - 1) / PAYLOAD_BITS;
  localparam int PAD_WIDTH    = NUM_BEATS * PAYLOAD_BITS;
  localparam logic [4:0] LAST_BEAT = 5'(NUM_BEATS - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [4:0]                     beat_q, beat_d;
  logic [DATA_DFX_WIDTH-1:0]      pkt_q, pkt_d;
  logic [AURORA_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                           tvalid_q, tvalid_d;
  logic                           tlast_q, tlast_d;
  logic [15:0]                    cnt_q, cnt_d;

  logic                           tx_hs;
  logic                           last_beat;
  logic                           accept;
  logic [DATA_DFX_WIDTH-1:0]      word_src;
  logic [4:0]                     word_idx;
  logic [AURORA_DATA_WIDTH-1:0]   word;

  // The packet is zero-extended to a whole number of beats, so the upper
  // payload bits of the last word come out as zero without a special case.
  function automatic logic [AURORA_DATA_WIDTH-1:0] make_word(
    input logic [DATA_DFX_WIDTH-1:0] pkt,
    input logic [4:0]                k
  );
    logic [PAD_WIDTH-1:0]    padded;
    logic [PAYLOAD_BITS-1:0] payload;
    logic [HDR_WIDTH-1:0]    hdr;
    padded  = PAD_WIDTH'(pkt);
    payload = padded[int'(k)*PAYLOAD_BITS +: PAYLOAD_BITS];
    hdr     = {k == 5'd0, k == LAST_BEAT, k, 2'b00};
    return {payload, hdr};
  endfunction

  assign tx_hs     = tvalid_q & tx_tready;
  assign last_beat = (beat_q == LAST_BEAT);
  assign accept    = valid_dfx_send & ready_dfx_send;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_dfx_send) state_d = SEND;
      SEND: if (tx_hs && last_beat && !valid_dfx_send) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ready opens during the last-beat handshake so a new packet
  // can be loaded in the same cycle the current one completes.
  always_comb begin
    ready_dfx_send = (state_q == IDLE) ||
                     ((state_q == SEND) && last_beat && tx_tready);
  end

  // Datapath: one word builder serves both loading beat 0 of a new packet and
  // advancing to the next beat of the current one.
  always_comb begin
    word_src = accept ? data_dfx_send : pkt_q;
    word_idx = accept ? 5'd0 : beat_q + 5'd1;
    word     = make_word(word_src, word_idx);

    pkt_d    = pkt_q;
    beat_d   = beat_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    cnt_d    = cnt_q;

    if (state_q == SEND && tx_hs && last_beat) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (accept) begin
      pkt_d    = data_dfx_send;
      beat_d   = 5'd0;
      tdata_d  = word;
      tvalid_d = 1'b1;
      tlast_d  = (word_idx == LAST_BEAT);
    end else if (state_q == SEND && tx_hs) begin
      if (!last_beat) begin
        beat_d  = word_idx;
        tdata_d = word;
        tlast_d = (word_idx == LAST_BEAT);
      end else begin
        tdata_d  = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q   <= '0;
      pkt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx_tdata     = tdata_q;
  assign tx_tvalid    = tvalid_q;
  assign tx_tlast     = tlast_q;
  assign pkt_sent_cnt = cnt_q;

endmodule

// File: tb/tb_encap_packet.sv
module tb_encap_packet;
  localparam int W = 1034;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  data_dfx_send;
  logic          valid_dfx_send;
  logic          ready_dfx_send;
  logic [63:0]   tx_tdata;
  logic          tx_tvalid;
  logic          tx_tlast;
  logic          tx_tready;
  logic [15:0]   pkt_sent_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  encap_packet dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_dfx_send  (data_dfx_send),
    .valid_dfx_send (valid_dfx_send),
    .ready_dfx_send (ready_dfx_send),
    .tx_tdata       (tx_tdata),
    .tx_tvalid      (tx_tvalid),
    .tx_tlast       (tx_tlast),
    .tx_tready      (tx_tready),
    .pkt_sent_cnt   (pkt_sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference word built bit by bit from the packet.
  function automatic logic [63:0] tb_word(input logic [W-1:0] p, input int k);
    logic [63:0] w;
    int src;
    w = '0;
    for (int i = 0; i < 55; i++) begin
      src = k * 55 + i;
      if (src < W) w[9+i] = p[src];
    end
    w[8]   = (k == 0);
    w[7]   = (k == 18);
    w[6:2] = 5'(k);
    return w;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input string tag, input logic [W-1:0] p);
    check({tag, "_ready_idle"}, 64'(ready_dfx_send), 64'd1);
    data_dfx_send  = p;
    valid_dfx_send = 1'b1;
    tick();
    valid_dfx_send = 1'b0;
  endtask

  // Checks all 19 words with tx_tready held high.
  task automatic run_pkt(input string tag, input logic [W-1:0] p);
    for (int k = 0; k < 19; k++) begin
      check($sformatf("%s_data_b%0d", tag, k), tx_tdata, tb_word(p, k));
      check($sformatf("%s_ctl_b%0d", tag, k), 64'({tx_tvalid, tx_tlast}),
            64'({1'b1, k == 18}));
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0]  pa, pb, p3, p5, p6;
    logic [63:0]   exp_w;
    logic [1087:0] rx_buf, ref_pad;
    int            hs_cnt, nb;
    bit            done;

    // Test 1: reset
    rst_n          = 1'b0;
    data_dfx_send  = '0;
    valid_dfx_send = 1'b0;
    tx_tready      = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_tdata", tx_tdata, 64'd0);
    check("rst_tlast", 64'(tx_tlast), 64'd0);
    check("rst_ready", 64'(ready_dfx_send), 64'd1);
    check("rst_cnt", 64'(pkt_sent_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Test 2: single packet, hand-computed words
    pa = '0;
    pa[54:0]     = 55'h1;
    pa[1033:990] = 44'hABC_DEF0_1234;
    tx_tready = 1'b1;
    send_pkt("t2", pa);
    for (int k = 0; k < 19; k++) begin
      if (k == 0)       exp_w = {55'h1, 9'h100};
      else if (k == 18) exp_w = {11'h0, 44'hABC_DEF0_1234, 9'h0C8};
      else              exp_w = {55'h0, 2'b00, 5'(k), 2'b00};
      check($sformatf("t2_data_b%0d", k), tx_tdata, exp_w);
      check($sformatf("t2_ctl_b%0d", k), 64'({tx_tvalid, tx_tlast}), 64'({1'b1, k == 18}));
      tick();
    end
    check("t2_tvalid_after", 64'(tx_tvalid), 64'd0);
    check("t2_cnt", 64'(pkt_sent_cnt), 64'd1);

    // Test 3: backpressure at beat 7, input data changes while in flight
    p3 = rand_pkt();
    send_pkt("t3", p3);
    hs_cnt = 0;
    for (int k = 0; k < 19; k++) begin
      if (k == 7) begin
        tx_tready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          data_dfx_send = rand_pkt();
          check($sformatf("t3_hold_data_%0d", s), tx_tdata, tb_word(p3, 7));
          check($sformatf("t3_hold_vld_%0d", s), 64'(tx_tvalid), 64'd1);
          tick();
        end
        tx_tready = 1'b1;
      end
      check($sformatf("t3_data_b%0d", k), tx_tdata, tb_word(p3, k));
      check($sformatf("t3_last_b%0d", k), 64'(tx_tlast), 64'(k == 18));
      if (tx_tvalid && tx_tready) hs_cnt++;
      tick();
    end
    check("t3_handshakes", 64'(hs_cnt), 64'd19);
    check("t3_cnt", 64'(pkt_sent_cnt), 64'd2);

    // Test 4: back-to-back packets A,B with valid held high
    pa = rand_pkt();
    pb = rand_pkt();
    data_dfx_send  = pa;
    valid_dfx_send = 1'b1;
    tick();
    data_dfx_send = pb;
    for (int n = 0; n < 38; n++) begin
      if (n == 19) valid_dfx_send = 1'b0;
      exp_w = (n < 19) ? tb_word(pa, n) : tb_word(pb, n - 19);
      check($sformatf("t4_data_w%0d", n), tx_tdata, exp_w);
      check($sformatf("t4_ctl_w%0d", n), 64'({tx_tvalid, tx_tlast}),
            64'({1'b1, (n % 19) == 18}));
      if (n == 5) check("t4_ready_mid", 64'(ready_dfx_send), 64'd0);
      if (n == 18) begin
        tx_tready = 1'b0;
        #1;
        check("t4_ready_last_nordy", 64'(ready_dfx_send), 64'd0);
        tx_tready = 1'b1;
        #1;
        check("t4_ready_last_rdy", 64'(ready_dfx_send), 64'd1);
      end
      tick();
    end
    check("t4_tvalid_after", 64'(tx_tvalid), 64'd0);
    check("t4_cnt", 64'(pkt_sent_cnt), 64'd4);

    // Test 5: reset mid-packet at beat 10
    p5 = rand_pkt();
    send_pkt("t5", p5);
    for (int k = 0; k < 10; k++) tick();
    check("t5_beat10", tx_tdata, tb_word(p5, 10));
    rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("t5_rst_tdata", tx_tdata, 64'd0);
    check("t5_rst_tlast", 64'(tx_tlast), 64'd0);
    check("t5_rst_cnt", 64'(pkt_sent_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_no_tail", 64'(tx_tvalid), 64'd0);
    p6 = rand_pkt();
    send_pkt("t5n", p6);
    run_pkt("t5n", p6);
    check("t5_cnt", 64'(pkt_sent_cnt), 64'd1);

    // Test 6: loopback through a payload-reassembling receiver, random stalls
    for (int j = 0; j < 3; j++) begin
      tx_tready = 1'b1;
      p6 = rand_pkt();
      send_pkt($sformatf("t6_%0d", j), p6);
      rx_buf = '0;
      nb     = 0;
      done   = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
        tx_tready = 1'($urandom_range(0, 1));
        if (tx_tvalid && tx_tready && nb < 19) begin
          rx_buf[nb*55 +: 55] = tx_tdata[63:9];
          nb++;
          if (tx_tlast) done = 1'b1;
        end
        tick();
      end
      check($sformatf("t6_%0d_done", j), 64'({done, 5'(nb)}), 64'({1'b1, 5'd19}));
      ref_pad = 1088'(p6);
      for (int c = 0; c < 17; c++)
        check($sformatf("t6_%0d_chunk%0d", j, c), rx_buf[c*64 +: 64], ref_pad[c*64 +: 64]);
      check($sformatf("t6_%0d_cnt", j), 64'(pkt_sent_cnt), 64'(j + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
